// File: rtl/sprite_pkg.sv
// Shared constants, types and the per-axis step helper for the sprite position controller.
// Defining SPRITE_WRAP_EN turns edge clamping into wrap-around.
package sprite_pkg;

  localparam int HRES        = 640;
  localparam int VRES        = 480;
  localparam int SPRITE_SIZE = 64;
  localparam int MAX_X       = HRES - SPRITE_SIZE;
  localparam int MAX_Y       = VRES - SPRITE_SIZE;

  // Bit positions of the buttons inside the packed button vectors.
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  typedef logic [9:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    UPDATE
  } state_t;

  // One step along one axis; 11-bit signed so that 0 - step is seen as negative.
  function automatic pos_t step_axis(input pos_t pos, input logic dec, input logic inc,
                                     input int step, input int max_pos);
    logic signed [10:0] cur;
    logic signed [10:0] delta;
    logic signed [10:0] nxt;
    logic signed [10:0] lim;
    pos_t               res;
    cur   = signed'({1'b0, pos});
    lim   = 11'(max_pos);
    delta = '0;
    if (inc && !dec) begin
      delta = 11'(step);
    end else if (dec && !inc) begin
      delta = -11'(step);
    end
    nxt = cur + delta;
    res = nxt[9:0];
`ifdef SPRITE_WRAP_EN
    if (nxt[10]) begin
      res = lim[9:0];
    end else if (nxt > lim) begin
      res = '0;
    end
`else
    if (nxt[10]) begin
      res = '0;
    end else if (nxt > lim) begin
      res = lim[9:0];
    end
`endif
    return res;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter for one button.
// level_next exposes the value level takes on the coming edge.
module button_debouncer
  import sprite_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic level_next
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // A sample equal to the current level leaves cnt_d at 0, restarting the run.
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = db_q;
  assign level_next = db_d;

endmodule

// File: rtl/sprite_position_controller.sv
// Moves the sprite one STEP per axis per frame from four debounced buttons.
// Define SPRITE_WRAP_EN to wrap at the screen edges instead of clamping.
module sprite_position_controller
  import sprite_pkg::*;
#(
  parameter int STEP      = 4,
  parameter int DB_CYCLES = 500000,
  parameter int INIT_X    = 288,
  parameter int INIT_Y    = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_end,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       moving
);

  logic [3:0] btn_raw;
  logic [3:0] lvl;
  logic [3:0] lvl_next;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      button_debouncer #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw[gi]),
        .level     (lvl[gi]),
        .level_next(lvl_next[gi])
      );
    end
  endgenerate

  state_t state_q, state_d;
  pos_t   posx_q, posx_d;
  pos_t   posy_q, posy_d;
  logic   moving_q, moving_d;

  always_comb begin
    state_d  = state_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    // Built from the debouncers' next levels so moving rises on the same edge they do.
    moving_d = |lvl_next;
    case (state_q)
      IDLE: begin
        if (moving_q) state_d = ARMED;
      end
      ARMED: begin
        if (frame_end) begin
          state_d = UPDATE;
        end else if (!moving_q) begin
          state_d = IDLE;
        end
      end
      UPDATE: begin
        state_d = moving_q ? ARMED : IDLE;
        posx_d  = step_axis(posx_q, lvl[BTN_LEFT], lvl[BTN_RIGHT], STEP, MAX_X);
        posy_d  = step_axis(posy_q, lvl[BTN_UP], lvl[BTN_DOWN], STEP, MAX_Y);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      posx_q   <= pos_t'(INIT_X);
      posy_q   <= pos_t'(INIT_Y);
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      moving_q <= moving_d;
    end
  end

  assign posx   = posx_q;
  assign posy   = posy_q;
  assign moving = moving_q;

endmodule

// File: doc/sprite_position_controller.md
SPRITE_POSITION_CONTROLLER -- requirements
Module: sprite_position_controller

Interface
REQ-001 SHALL have parameter STEP, default 4, pixels moved per frame per axis.
REQ-002 SHALL have parameter DB_CYCLES, default 500000, consecutive stable clk cycles required to accept a button change.
REQ-003 SHALL have parameters INIT_X and INIT_Y, defaults 288 and 208, the sprite top-left position after reset.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have ports btn_up, btn_down, btn_left and btn_right, input, 1 bit each, raw active-high buttons asynchronous to clk.
REQ-007 SHALL have port frame_end, input, 1 bit, one-cycle pulse from the VGA timing stage after the last visible pixel of a frame.
REQ-008 SHALL have ports posx and posy, output, 10 bits each, sprite top-left position consumed by the address generator.
REQ-009 SHALL have port moving, output, 1 bit, high while any debounced direction is pressed.

Function
REQ-010 SHALL pass each button through a 2-flop synchroniser, then through a debouncer.
REQ-011 The debouncer output SHALL change only after the synchronised input differs from it for DB_CYCLES consecutive cycles; any glitch SHALL restart the count from 0.
REQ-012 The FSM SHALL have states IDLE, ARMED and UPDATE.
- IDLE -> ARMED when moving=1.
- ARMED -> UPDATE on frame_end=1.
- ARMED -> IDLE when moving=0 and frame_end=0.
- UPDATE -> ARMED if moving=1, else IDLE.
REQ-013 In UPDATE, SHALL apply one step per axis using the debounced levels sampled in that cycle.
REQ-014 posx/posy SHALL change only on the clock edge that leaves UPDATE, exactly 2 edges after the frame_end edge; they SHALL be constant at all other times.
REQ-015 Axis rules:
- Left: posx -= STEP.
- Right: posx += STEP.
- Up: posy -= STEP.
- Down: posy += STEP.
- Both opposing buttons pressed: that axis SHALL NOT change.
REQ-016 Arithmetic SHALL use 11-bit signed intermediates, so there is no 10-bit wrap error.
REQ-017 Bounds are MAX_X=576 (640-64) and MAX_Y=416 (480-64); without SPRITE_WRAP_EN, results SHALL clamp to [0, MAX_X] and [0, MAX_Y].
REQ-018 A frame_end that arrives while the FSM is in IDLE or UPDATE SHALL be ignored; there SHALL be at most one step per frame.
REQ-019 moving SHALL be the registered OR of the four debounced levels.

Reset
REQ-020 While rst_n=0, SHALL hold:
- posx=INIT_X, posy=INIT_Y.
- moving=0, state=IDLE.
- synchronisers, debounced levels and debounce counters all 0.
REQ-021 Reset asserted mid-UPDATE SHALL discard the pending step; the first step after release SHALL require a fresh debounce and frame_end.

Configuration
REQ-022 With SPRITE_WRAP_EN defined, an overflowing step SHALL wrap instead of clamping:
- Stepping below 0 loads MAX_X or MAX_Y.
- Stepping above MAX_X or MAX_Y loads 0.
REQ-023 Without SPRITE_WRAP_EN, SHALL apply the clamp behaviour of REQ-017; no wrap logic is synthesised.

Structure
REQ-024 Package sprite_pkg SHALL hold:
- Constants HRES=640, VRES=480, SPRITE_SIZE=64, MAX_X, MAX_Y.
- typedef pos_t, logic [9:0].
- enum state_t {IDLE, ARMED, UPDATE}.
REQ-025 Sub-module button_debouncer (parameter DB_CYCLES, containing the synchroniser and counter) SHALL be instantiated four times.

Verification (bench uses DB_CYCLES=4)
REQ-026 Reset release, no buttons, 3 frame_end pulses -> posx=288, posy=208, moving=0 throughout.
REQ-027 btn_right held 10 cycles, then 2 frame_end pulses -> moving=1 after 6 edges; posx=292, then 296; each update lands 2 edges after its pulse; posy=208.
REQ-028 btn_right glitches (high 2 cycles, low 1 cycle, repeated) -> moving stays 0, posx unchanged.
REQ-029 Start posx=4, btn_left held, 3 frames -> clamp build: 0, 0, 0; SPRITE_WRAP_EN build: 0, 576, 572.
REQ-030 btn_up+btn_down+btn_right held, one frame -> posy=208, posx=292.
REQ-031 rst_n pulsed low on the cycle the FSM enters UPDATE -> posx=288, posy=208, state IDLE; no step until 4 stable cycles plus a new frame_end.
